cab_master: RTL and testbench
=============================

CAB_MASTER -- requirements
Module: cab_master

Interface
REQ-001 SHALL have parameter TO_W, default 8, meaning read-timeout counter width; timeout limit is 2^TO_W-1 cycles.
REQ-002 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  in  1  reset: asynchronous, active-low.
REQ-004 SHALL have port host_req  in  1  host requests one register access.
REQ-005 SHALL have port host_wr  in  1  1=write, 0=read.
REQ-006 SHALL have port host_addr  in  14  register word address.
REQ-007 SHALL have port host_ctrl  in  1  control-space select.
REQ-008 SHALL have port host_wdata  in  32  write data.
REQ-009 SHALL have port host_rdy  out  1  combinational; request accepted when host_req && host_rdy.
REQ-010 SHALL have port host_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have port host_err  out  1  qualifies host_ack; 1=read timeout or protocol error.
REQ-012 SHALL have port host_rdata  out  32  read data, valid with host_ack.
REQ-013 SHALL have port cab_xx_req_vld  out  1  CAB request word valid.
REQ-014 SHALL have port cab_xx_req_data  out  16  CAB request word.
REQ-015 SHALL have port xx_cab_ack_vld  in  1  CAB ack word valid.
REQ-016 SHALL have port xx_cab_ack_data  in  16  CAB ack word.
REQ-017 SHALL have port xx_cab_rdy  in  1  slave can accept a new command.

Function
REQ-018 SHALL implement one-hot FSM IDLE, WR_LO, WR_HI, RD_LO, RD_HI.
REQ-019 SHALL drive host_rdy = (state==IDLE) && xx_cab_rdy.
REQ-020 SHALL, on acceptance in cycle T, register the command and drive the address word {addr[13:0], ctrl, wr} with vld=1 in cycle T+1; next state WR_LO (write) or RD_LO (read).
REQ-021 SHALL, for writes, drive wdata[15:0] in T+2 and wdata[31:16] in T+3 with vld=1, in consecutive cycles, never waiting on xx_cab_rdy.
REQ-022 SHALL pulse host_ack=1, host_err=0 in T+3 (posted write) and return to IDLE, so a request accepted in T+3 puts its address word on the bus in T+4.
REQ-023 SHALL drive cab_xx_req_data=0 whenever cab_xx_req_vld=0.
REQ-024 SHALL, in RD_LO, capture ack_data as rdata[15:0] on the first xx_cab_ack_vld and go to RD_HI.
REQ-025 SHALL, in RD_HI, capture ack_data as rdata[31:16] if ack_vld=1 and pulse host_ack (err=0) with host_rdata in the next cycle; if ack_vld=0, pulse host_ack with err=1, rdata=0; either case returns to IDLE.
REQ-026 SHALL count cycles in RD_LO from 0; on reaching 2^TO_W-1 without ack_vld, pulse host_ack with err=1, rdata=0 and return to IDLE.
REQ-027 SHALL ignore xx_cab_ack_vld in IDLE, WR_LO and WR_HI (stray words discarded, no state change).
REQ-028 SHALL hold host_rdata stable between host_ack pulses; host_err is 0 when host_ack=0.
REQ-029 SHALL keep host_rdy low after a timeout until the slave raises xx_cab_rdy.

Reset
REQ-030 SHALL on rst_n low, at any time including mid-transaction, force state IDLE, cab_xx_req_vld=0, cab_xx_req_data=0, host_ack=0, host_err=0, host_rdata=0, timeout counter=0, with no completion pulse for the aborted access.

Structure
REQ-031 SHALL take state encodings and word-field positions (ADDR [15:2], CTRL [1], WR [0]) from shared package cab_pkg, also used by cab_slave.
REQ-032 SHALL be a single module; no sub-module is required.

Verification
REQ-033 Write addr 0x0123, ctrl 0, wdata 0xCAFEF00D, rdy=1 -> bus words 0x048D, 0xF00D, 0xCAFE on three consecutive cycles; host_ack, err=0 with third word.
REQ-034 Read addr 0x3FFF, ctrl 1 -> word 0xFFFE; slave ack words 0x5678 then 0x1234 -> host_rdata 0x12345678, err=0 the cycle after 0x1234.
REQ-035 Read with no ack words -> host_ack, err=1, rdata 0 after 255 cycles in RD_LO (TO_W=8); host_rdy stays 0 while xx_cab_rdy=0.
REQ-036 host_req=1 with xx_cab_rdy=0 in IDLE -> host_rdy=0, no bus word until rdy returns, then address word the next cycle.
REQ-037 Two back-to-back writes -> six consecutive valid words, no idle gap; two host_ack pulses 3 cycles apart.
REQ-038 rst_n asserted in RD_LO, ack words arriving after release -> vld=0, state IDLE, no host_ack, stray words ignored.

Source files
------------

// File: rtl/cab_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cab_pkg
//  Brief    : Shared CAB definitions: FSM state encodings and request-word
//             field positions used by both cab_master and cab_slave.
//  Revision : 1.0 - initial release
// ============================================================================
package cab_pkg;

    // One-hot master states
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        WR_LO = 5'b00010,
        WR_HI = 5'b00100,
        RD_LO = 5'b01000,
        RD_HI = 5'b10000
    } cab_state_e;

    // Address/command word field positions
    localparam int CAB_ADDR_MSB = 15;
    localparam int CAB_ADDR_LSB = 2;
    localparam int CAB_CTRL_BIT = 1;
    localparam int CAB_WR_BIT   = 0;

    // Build the first word of a command: {addr, ctrl, wr}
    function automatic logic [15:0] cab_cmd_word(input logic [13:0] addr,
                                                 input logic        ctrl,
                                                 input logic        wr);
        logic [15:0] w;
        w = '0;
        w[CAB_ADDR_MSB:CAB_ADDR_LSB] = addr;
        w[CAB_CTRL_BIT]              = ctrl;
        w[CAB_WR_BIT]                = wr;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cab_master.sv
`default_nettype none
// ============================================================================
//  Module   : cab_master
//  Brief    : Host-to-CAB bridge. Serialises one 32-bit register access into
//             16-bit CAB request words; writes are posted, reads wait for two
//             ack words from the slave with a bounded timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module cab_master
    import cab_pkg::*;
#(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [13:0] host_addr,
    input  logic        host_ctrl,
    input  logic [31:0] host_wdata,
    output logic        host_rdy,
    output logic        host_ack,
    output logic        host_err,
    output logic [31:0] host_rdata,
    output logic        cab_xx_req_vld,
    output logic [15:0] cab_xx_req_data,
    input  logic        xx_cab_ack_vld,
    input  logic [15:0] xx_cab_ack_data,
    input  logic        xx_cab_rdy
);

    // Last RD_LO count value before the timeout fires; the limit is
    // therefore 2^TO_W-1 cycles spent in RD_LO.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);

    cab_state_e        state_q,   state_d;
    logic              req_vld_q, req_vld_d;
    logic [15:0]       req_data_q, req_data_d;
    logic              ack_q,     ack_d;
    logic              err_q,     err_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [15:0]       rd_lo_q,   rd_lo_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;

    assign host_rdy        = (state_q == IDLE) && xx_cab_rdy;
    assign host_ack        = ack_q;
    assign host_err        = err_q;
    assign host_rdata      = rdata_q;
    assign cab_xx_req_vld  = req_vld_q;
    assign cab_xx_req_data = req_data_q;

    // Next-state and next-output computation; bus data defaults to zero so
    // it is only non-zero alongside a valid word.
    always_comb begin
        state_d    = state_q;
        req_vld_d  = 1'b0;
        req_data_d = 16'h0000;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        rd_lo_d    = rd_lo_q;
        wdata_d    = wdata_q;
        to_cnt_d   = '0;
        case (state_q)
            IDLE: begin
                // Stray ack words are ignored here
                if (host_req && host_rdy) begin
                    req_vld_d  = 1'b1;
                    req_data_d = cab_cmd_word(host_addr, host_ctrl, host_wr);
                    wdata_d    = host_wdata;
                    state_d    = host_wr ? WR_LO : RD_LO;
                end
            end
            WR_LO: begin
                req_vld_d  = 1'b1;
                req_data_d = wdata_q[15:0];
                state_d    = WR_HI;
            end
            WR_HI: begin
                // Posted write: complete with the last data word
                req_vld_d  = 1'b1;
                req_data_d = wdata_q[31:16];
                ack_d      = 1'b1;
                state_d    = IDLE;
            end
            RD_LO: begin
                if (xx_cab_ack_vld) begin
                    rd_lo_d = xx_cab_ack_data;
                    state_d = RD_HI;
                end else if (to_cnt_q == TO_LAST) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RD_HI: begin
                // Upper half must follow immediately, otherwise protocol error
                ack_d = 1'b1;
                if (xx_cab_ack_vld) begin
                    rdata_d = {xx_cab_ack_data, rd_lo_q};
                end else begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access without a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_vld_q  <= 1'b0;
            req_data_q <= 16'h0000;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            rd_lo_q    <= 16'h0000;
            wdata_q    <= 32'h0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_vld_q  <= req_vld_d;
            req_data_q <= req_data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rd_lo_q    <= rd_lo_d;
            wdata_q    <= wdata_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cab_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cab_master
//  Brief    : Directed self-checking bench for cab_master.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cab_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req, host_wr, host_ctrl;
    logic [13:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rdy, host_ack, host_err;
    logic [31:0] host_rdata;
    logic        cab_xx_req_vld;
    logic [15:0] cab_xx_req_data;
    logic        xx_cab_ack_vld;
    logic [15:0] xx_cab_ack_data;
    logic        xx_cab_rdy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cab_master #(.TO_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_req        (host_req),
        .host_wr         (host_wr),
        .host_addr       (host_addr),
        .host_ctrl       (host_ctrl),
        .host_wdata      (host_wdata),
        .host_rdy        (host_rdy),
        .host_ack        (host_ack),
        .host_err        (host_err),
        .host_rdata      (host_rdata),
        .cab_xx_req_vld  (cab_xx_req_vld),
        .cab_xx_req_data (cab_xx_req_data),
        .xx_cab_ack_vld  (xx_cab_ack_vld),
        .xx_cab_ack_data (xx_cab_ack_data),
        .xx_cab_rdy      (xx_cab_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus and completion outputs in one go
    task automatic bus(input string tag, input logic v, input logic [15:0] d,
                       input logic a, input logic e);
        chk({tag, "_vld"},  {31'h0, cab_xx_req_vld}, {31'h0, v});
        chk({tag, "_data"}, {16'h0, cab_xx_req_data}, {16'h0, d});
        chk({tag, "_ack"},  {31'h0, host_ack}, {31'h0, a});
        chk({tag, "_err"},  {31'h0, host_err}, {31'h0, e});
    endtask

    // Advance to just after the next falling edge
    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    // Present a request and confirm it will be accepted at the next edge
    task automatic req(input string tag, input logic wr, input logic [13:0] addr,
                       input logic ctrl, input logic [31:0] wdata);
        host_req   = 1'b1;
        host_wr    = wr;
        host_addr  = addr;
        host_ctrl  = ctrl;
        host_wdata = wdata;
        #1;
        chk({tag, "_rdy"}, {31'h0, host_rdy}, 32'h1);
    endtask

    logic [15:0] b2b_data [6];
    logic        b2b_ack  [6];
    logic        early, rdy_seen;

    initial begin
        b2b_data = '{16'h0007, 16'h5555, 16'hAAAA, 16'h8001, 16'h1E1E, 16'h0F0F};
        b2b_ack  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; host_req = 1'b0; host_wr = 1'b0; host_addr = '0;
        host_ctrl = 1'b0; host_wdata = '0; xx_cab_ack_vld = 1'b0;
        xx_cab_ack_data = '0; xx_cab_rdy = 1'b1;

        // Reset state
        repeat (2) nx();
        bus("rst", 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_rdata", host_rdata, 32'h0);
        chk("rst_rdy", {31'h0, host_rdy}, 32'h1);
        rst_n = 1'b1;
        nx();

        // Single posted write
        req("w", 1'b1, 14'h0123, 1'b0, 32'hCAFEF00D);
        nx(); host_req = 1'b0;
        bus("w_a", 1'b1, 16'h048D, 1'b0, 1'b0);
        nx(); bus("w_lo", 1'b1, 16'hF00D, 1'b0, 1'b0);
        nx(); bus("w_hi", 1'b1, 16'hCAFE, 1'b1, 1'b0);
        nx(); bus("w_end", 1'b0, 16'h0, 1'b0, 1'b0);

        // Read with two ack words
        req("r", 1'b0, 14'h3FFF, 1'b1, 32'h0);
        nx(); host_req = 1'b0;
        bus("r_a", 1'b1, 16'hFFFE, 1'b0, 1'b0);
        xx_cab_ack_vld = 1'b1; xx_cab_ack_data = 16'h5678;
        nx(); bus("r_lo", 1'b0, 16'h0, 1'b0, 1'b0);
        xx_cab_ack_data = 16'h1234;
        nx(); xx_cab_ack_vld = 1'b0; xx_cab_ack_data = 16'h0;
        bus("r_ack", 1'b0, 16'h0, 1'b1, 1'b0);
        chk("r_rdata", host_rdata, 32'h12345678);
        nx(); chk("r_ack_gone", {31'h0, host_ack}, 32'h0);
        chk("r_rdata_hold", host_rdata, 32'h12345678);

        // Back-to-back writes with stray ack words present throughout
        xx_cab_ack_vld = 1'b1; xx_cab_ack_data = 16'hBEEF;
        req("b1", 1'b1, 14'h0001, 1'b1, 32'hAAAA5555);
        for (int i = 0; i < 6; i++) begin
            nx();
            if (i == 0 || i == 3) host_req = 1'b0;
            bus($sformatf("b2b%0d", i), 1'b1, b2b_data[i], b2b_ack[i], 1'b0);
            if (i == 2) req("b2", 1'b1, 14'h2000, 1'b0, 32'h0F0F1E1E);
        end
        nx(); xx_cab_ack_vld = 1'b0; xx_cab_ack_data = 16'h0;
        bus("b_end", 1'b0, 16'h0, 1'b0, 1'b0);
        chk("b_rdata_hold", host_rdata, 32'h12345678);

        // Read timeout with the slave not ready afterwards
        req("t", 1'b0, 14'h0002, 1'b0, 32'h0);
        early = 1'b0; rdy_seen = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            nx();
            if (k == 1) begin
                host_req = 1'b0;
                bus("t_a", 1'b1, 16'h0008, 1'b0, 1'b0);
                xx_cab_rdy = 1'b0;
                #1;
            end
            if (k < 256 && host_ack) early = 1'b1;
            if (host_rdy) rdy_seen = 1'b1;
            if (k == 256) begin
                bus("t_ack", 1'b0, 16'h0, 1'b1, 1'b1);
                chk("t_rdata", host_rdata, 32'h0);
            end
        end
        chk("t_early", {31'h0, early}, 32'h0);
        nx();
        if (host_rdy) rdy_seen = 1'b1;
        chk("t_rdy_low", {31'h0, rdy_seen}, 32'h0);
        chk("t_ack_gone", {31'h0, host_ack}, 32'h0);
        xx_cab_rdy = 1'b1; #1;
        chk("t_rdy_back", {31'h0, host_rdy}, 32'h1);

        // Request held while the slave is not ready
        xx_cab_rdy = 1'b0;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 14'h0010;
        host_ctrl = 1'b0; host_wdata = 32'h13572468;
        #1; chk("s_rdy0", {31'h0, host_rdy}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            nx();
            bus($sformatf("s_wait%0d", i), 1'b0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("s_rdy_wait%0d", i), {31'h0, host_rdy}, 32'h0);
        end
        xx_cab_rdy = 1'b1; #1;
        chk("s_rdy1", {31'h0, host_rdy}, 32'h1);
        nx(); host_req = 1'b0;
        bus("s_a", 1'b1, 16'h0041, 1'b0, 1'b0);
        nx(); bus("s_lo", 1'b1, 16'h2468, 1'b0, 1'b0);
        nx(); bus("s_hi", 1'b1, 16'h1357, 1'b1, 1'b0);

        // Second ack word missing -> protocol error
        nx();
        req("e", 1'b0, 14'h0004, 1'b0, 32'h0);
        nx(); host_req = 1'b0;
        bus("e_a", 1'b1, 16'h0010, 1'b0, 1'b0);
        xx_cab_ack_vld = 1'b1; xx_cab_ack_data = 16'h9999;
        nx(); xx_cab_ack_vld = 1'b0; xx_cab_ack_data = 16'h0;
        bus("e_lo", 1'b0, 16'h0, 1'b0, 1'b0);
        nx(); bus("e_ack", 1'b0, 16'h0, 1'b1, 1'b1);
        chk("e_rdata", host_rdata, 32'h0);

        // Reset asserted while waiting in RD_LO, acks arrive afterwards
        nx();
        req("x", 1'b0, 14'h0002, 1'b0, 32'h0);
        nx(); host_req = 1'b0;
        bus("x_a", 1'b1, 16'h0008, 1'b0, 1'b0);
        nx(); chk("x_busy", {31'h0, host_rdy}, 32'h0);
        rst_n = 1'b0; #1;
        chk("x_rst_rdy", {31'h0, host_rdy}, 32'h1);
        bus("x_rst", 1'b0, 16'h0, 1'b0, 1'b0);
        nx(); rst_n = 1'b1;
        xx_cab_ack_vld = 1'b1; xx_cab_ack_data = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            nx();
            bus($sformatf("x_stray%0d", i), 1'b0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("x_rdy%0d", i), {31'h0, host_rdy}, 32'h1);
        end
        xx_cab_ack_vld = 1'b0;
        chk("x_rdata", host_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
